// File: rtl/floo_mcast_id_expander.sv
// Multicast descriptor expander: enumerates every (X,Y) endpoint covered by base+mask, X inner loop.
// Optional beat index counter on idx_o is built only when FLOO_MCAST_EXPAND_IDX_EN is defined.
module floo_mcast_id_expander #(
    parameter int unsigned XWidth = 4,
    parameter int unsigned YWidth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [XWidth-1:0]          x_i,
    input  logic [YWidth-1:0]          y_i,
    input  logic [XWidth-1:0]          mask_x_i,
    input  logic [YWidth-1:0]          mask_y_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [XWidth-1:0]          x_o,
    output logic [YWidth-1:0]          y_o,
    output logic                       last_o,
    output logic [XWidth+YWidth-1:0]   idx_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [XWidth-1:0] x_q, x_d, mx_q, mx_d, sx_q, sx_d, sx_nxt;
    logic [YWidth-1:0] y_q, y_d, my_q, my_d, sy_q, sy_d, sy_nxt;
    logic              accept, hs;

    assign valid_o = (state_q == EXPAND);
    assign last_o  = valid_o && (sx_q == mx_q) && (sy_q == my_q);
    assign ready_o = (state_q == IDLE) || (valid_o && ready_i && last_o);
    assign accept  = valid_i && ready_o;
    assign hs      = valid_o && ready_i;

    assign x_o = (x_q & ~mx_q) | sx_q;
    assign y_o = (y_q & ~my_q) | sy_q;

    // Forcing the non-mask bits to 1 lets the +1 carry ripple straight to the next mask bit.
    assign sx_nxt = ((sx_q | ~mx_q) + XWidth'(1)) & mx_q;
    assign sy_nxt = ((sy_q | ~my_q) + YWidth'(1)) & my_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mx_d    = mx_q;
        my_d    = my_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        if (accept) begin
            state_d = EXPAND;
            x_d     = x_i;
            y_d     = y_i;
            mx_d    = mask_x_i;
            my_d    = mask_y_i;
            sx_d    = '0;
            sy_d    = '0;
        end else if (hs) begin
            if (last_o) begin
                state_d = IDLE;
            end else if (sx_q == mx_q) begin
                sx_d = '0;
                sy_d = sy_nxt;
            end else begin
                sx_d = sx_nxt;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

`ifdef FLOO_MCAST_EXPAND_IDX_EN
    logic [XWidth+YWidth-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if (hs) begin
            idx_d = idx_q + (XWidth+YWidth)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;
`else
    assign idx_o = '0;
`endif

endmodule

// File: tb/tb_floo_mcast_id_expander.sv
// Directed bench for floo_mcast_id_expander: table of descriptors with expected beat sequences.
module tb_floo_mcast_id_expander;

`ifdef FLOO_MCAST_EXPAND_IDX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [3:0] x_i = '0, y_i = '0, mask_x_i = '0, mask_y_i = '0;
    logic       valid_o;
    logic       ready_i = 1'b1;
    logic [3:0] x_o, y_o;
    logic       last_o;
    logic [7:0] idx_o;

    int total = 0;
    int bad   = 0;

    floo_mcast_id_expander #(.XWidth(4), .YWidth(4)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .x_i      (x_i),
        .y_i      (y_i),
        .mask_x_i (mask_x_i),
        .mask_y_i (mask_y_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .x_o      (x_o),
        .y_o      (y_o),
        .last_o   (last_o),
        .idx_o    (idx_o)
    );

    always #5 clk = ~clk;

    // Expected beat i lives in nibble i of ex/ey.
    typedef struct packed {
        logic [3:0]  x, y, mx, my;
        logic [3:0]  n;
        logic [31:0] ex, ey;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                            input logic el, input int i);
        chk({tag, " valid"}, 32'(valid_o), 32'd1);
        chk({tag, " x"},     32'(x_o),     32'(ex));
        chk({tag, " y"},     32'(y_o),     32'(ey));
        chk({tag, " last"},  32'(last_o),  32'(el));
        chk({tag, " idx"},   32'(idx_o),   IDX_EN ? 32'(i) : 32'd0);
    endtask

    task automatic drive_desc(input logic [3:0] x, input logic [3:0] y,
                              input logic [3:0] mx, input logic [3:0] my);
        valid_i = 1'b1; x_i = x; y_i = y; mask_x_i = mx; mask_y_i = my;
    endtask

    // Accepts v from IDLE and drains every beat with ready_i held high.
    task automatic run_vec(input vec_t v, input int k);
        string tag;
        @(negedge clk);
        ready_i = 1'b1;
        drive_desc(v.x, v.y, v.mx, v.my);
        chk($sformatf("v%0d ready_idle", k), 32'(ready_o), 32'd1);
        @(posedge clk);
        for (int i = 0; i < int'(v.n); i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            tag = $sformatf("v%0d b%0d", k, i);
            chk_beat(tag, v.ex[4*i +: 4], v.ey[4*i +: 4], (i == int'(v.n) - 1), i);
            @(posedge clk);
        end
        @(negedge clk);
        chk($sformatf("v%0d valid_after", k), 32'(valid_o), 32'd0);
        chk($sformatf("v%0d ready_after", k), 32'(ready_o), 32'd1);
    endtask

    initial begin
        vecs[0] = '{x:4'd3, y:4'd5, mx:4'h0, my:4'h0, n:4'd1, ex:32'h3,        ey:32'h5};
        vecs[1] = '{x:4'h4, y:4'd1, mx:4'h3, my:4'h0, n:4'd4, ex:32'h7654,     ey:32'h1111};
        vecs[2] = '{x:4'h0, y:4'd2, mx:4'hA, my:4'h1, n:4'd8, ex:32'hA820A820, ey:32'h33332222};
        vecs[3] = '{x:4'h0, y:4'd3, mx:4'hA, my:4'h1, n:4'd8, ex:32'hA820A820, ey:32'h33332222};
        vecs[4] = '{x:4'h9, y:4'h8, mx:4'h0, my:4'h3, n:4'd4, ex:32'h9999,     ey:32'hBA98};
        vecs[5] = '{x:4'hF, y:4'h0, mx:4'h8, my:4'h0, n:4'd2, ex:32'hF7,       ey:32'h00};

        // Reset state
        #12;
        chk("rst valid", 32'(valid_o), 32'd0);
        chk("rst ready", 32'(ready_o), 32'd1);
        chk("rst x",     32'(x_o),     32'd0);
        chk("rst y",     32'(y_o),     32'd0);
        chk("rst last",  32'(last_o),  32'd0);
        chk("rst idx",   32'(idx_o),   32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Backpressure on beat 2 of the X-only case
        @(negedge clk);
        drive_desc(4'h4, 4'd1, 4'h3, 4'h0);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        chk_beat("bp b0", 4'd4, 4'd1, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_beat($sformatf("bp hold%0d", c), 4'd5, 4'd1, 1'b0, 1);
            chk($sformatf("bp hold%0d ready_o", c), 32'(ready_o), 32'd0);
            @(negedge clk);
        end
        ready_i = 1'b1;
        chk_beat("bp b1", 4'd5, 4'd1, 1'b0, 1);
        @(posedge clk);
        @(negedge clk);
        chk_beat("bp b2", 4'd6, 4'd1, 1'b0, 2);
        @(posedge clk);
        @(negedge clk);
        chk_beat("bp b3", 4'd7, 4'd1, 1'b1, 3);
        @(posedge clk);
        @(negedge clk);
        chk("bp done valid", 32'(valid_o), 32'd0);

        // Back-to-back: unicast (7,7) presented during the last beat of the X-only case
        drive_desc(4'h4, 4'd1, 4'h3, 4'h0);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            chk_beat($sformatf("b2b b%0d", i), 4'(4 + i), 4'd1, (i == 3), i);
            if (i == 3) begin
                drive_desc(4'd7, 4'd7, 4'h0, 4'h0);
                chk("b2b ready_o on last", 32'(ready_o), 32'd1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        valid_i = 1'b0;
        chk_beat("b2b second", 4'd7, 4'd7, 1'b1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b done valid", 32'(valid_o), 32'd0);

        // Reset during beat 3 of the sparse XY case
        drive_desc(4'h0, 4'd2, 4'hA, 4'h1);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        chk_beat("mr b0", 4'h0, 4'd2, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_beat("mr b1", 4'h2, 4'd2, 1'b0, 1);
        @(posedge clk);
        @(negedge clk);
        chk_beat("mr b2", 4'h8, 4'd2, 1'b0, 2);
        rst_ni = 1'b0;
        #1;
        chk("mr valid", 32'(valid_o), 32'd0);
        chk("mr ready", 32'(ready_o), 32'd1);
        chk("mr last",  32'(last_o),  32'd0);
        chk("mr idx",   32'(idx_o),   32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        drive_desc(4'd1, 4'd1, 4'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        chk_beat("mr uni", 4'd1, 4'd1, 1'b1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mr uni done valid", 32'(valid_o), 32'd0);
        chk("mr uni done ready", 32'(ready_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/floo_mcast_id_expander.md
# floo_mcast_id_expander

Expands one multicast destination descriptor (base endpoint ID plus X/Y mask selections, as produced by the address-to-ID translation stage) into the full sequence of unicast endpoint IDs it covers. The block emits one ID per output handshake. It sits on the receive/replication side of the network interface, wherever a collective request must be fanned out to explicit destinations. It is a two-state sequencer with valid/ready handshakes on both sides.

## Interface
- `XWidth`, default 4: width of the X coordinate and the X mask.
- `YWidth`, default 4: width of the Y coordinate and the Y mask.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. Asynchronous and active-low.
- `valid_i`  in  1: descriptor valid.
- `ready_o`  out  1: descriptor accepted when `valid_i && ready_o`.
- `x_i`  in  XWidth: base X coordinate.
- `y_i`  in  YWidth: base Y coordinate.
- `mask_x_i`  in  XWidth: X bits to enumerate (1 = wildcard).
- `mask_y_i`  in  YWidth: Y bits to enumerate.
- `valid_o`  out  1: output ID valid.
- `ready_i`  in  1: downstream ready.
- `x_o`  out  XWidth: expanded X coordinate.
- `y_o`  out  YWidth: expanded Y coordinate.
- `last_o`  out  1: final beat of the current descriptor.
- `idx_o`  out  XWidth+YWidth: beat index within the descriptor (see Configuration).

## Operation
- States: IDLE and EXPAND.
- Registered per descriptor: base X/Y, masks, and submask counters `sub_x` and `sub_y`.
- Output coordinates:
  - `x_o = (base_x & ~mask_x) | sub_x`
  - `y_o = (base_y & ~mask_y) | sub_y`
  - Base bits under the mask are ignored.
- Submask enumeration runs in ascending order:
  - Next X submask: `sub_x' = ((sub_x | ~mask_x) + 1) & mask_x`, computed mod 2^XWidth.
  - The same rule applies to Y.
- Ordering:
  - X is the inner loop and Y is the outer loop.
  - On an output handshake with `sub_x == mask_x`: `sub_x` wraps to 0 and `sub_y` advances.
  - Otherwise only `sub_x` advances.
- `last_o = (sub_x == mask_x) && (sub_y == mask_y)`.
- Beat count is 2^(popcount(mask_x)+popcount(mask_y)).
- Both masks zero (unicast): exactly one beat, with `last_o = 1`.
- `ready_o = (state == IDLE) || (valid_o && ready_i && last_o)`. This is combinational, with no combinational path from `valid_i`.
- IDLE → EXPAND on input accept. On accept, load the descriptor and set `sub_x = sub_y = 0`.
- EXPAND → IDLE on the last output handshake, unless a new descriptor is accepted in the same cycle. In that case, stay in EXPAND with the new descriptor loaded.
- `valid_o = (state == EXPAND)`.
- While `valid_o && !ready_i`, all outputs hold stable (AXI-style).
- Reset values: state IDLE, `valid_o` 0, `x_o`/`y_o` 0, `last_o` 0, `idx_o` 0, `ready_o` 1.
- Reset mid-expansion: the remaining beats are discarded and no partial state survives.

## Timing
- Latency: a descriptor accepted at edge t presents its first beat in the cycle after t. The output is registered.
- Throughput: one beat per cycle while `ready_i` is high.
- Back-to-back: descriptor k+1 is accepted on the last handshake of k, and its first beat follows with no bubble.
- All outputs are driven from flops, except `ready_o`, which depends on state and `ready_i`.

## Configuration
- `FLOO_MCAST_EXPAND_IDX_EN` defined:
  - An (XWidth+YWidth)-bit beat counter clears on accept and increments on each output handshake.
  - `idx_o` = the counter value, i.e. 0 for the first beat of each descriptor.
- Not defined: no counter is built and `idx_o` is tied to 0. All other behaviour is identical.

## Test plan
- Unicast: `x_i`=3, `y_i`=5, masks 0, accept at t → one beat (3,5) with `last_o`=1, valid in the cycle after t; `ready_o`=1 after the handshake.
- X-only: `x_i`=0b0100, `mask_x_i`=0b0011, `y_i`=1 → beats X=4,5,6,7 with Y=1; `last_o` only on X=7; `idx_o` 0..3 when the macro is defined.
- Sparse XY: `x_i`=0, `y_i`=2, `mask_x_i`=0b1010, `mask_y_i`=0b0001 → (0,2),(2,2),(8,2),(10,2),(0,3),(2,3),(8,3),(10,3), with `last_o` on the 8th beat.
- Sparse XY variant: same as above but `y_i`=3 → identical sequence, confirming base bits under the mask are ignored.
- Backpressure: `ready_i` low for 3 cycles on beat 2 of the X-only case → `valid_o`, `x_o`, `y_o`, `last_o`, `idx_o` held stable; no beat skipped or duplicated.
- Back-to-back: the second descriptor (unicast 7,7) is held valid during the last beat of the first → accepted on that handshake; beat (7,7) appears next cycle with no idle cycle.
- Reset mid-run: `rst_ni` low during beat 3 of 8 → `valid_o`=0 and `ready_o`=1 immediately; after release, a new unicast descriptor (1,1) produces a single correct beat.
